corevx_mem_arbiter: RTL and testbench

Two-master, burst-aware arbiter sharing the single Avalon-style memory port (m_*) between the data cache (port 0) and the instruction cache (port 1). It holds a grant for a whole burst: a read until all readdatavalid beats return, a write until all write beats are accepted. It then releases the bus and re-arbitrates. It sits between the two corevx_cache instances and the memory/PMA fabric.

---
 rtl/corevx_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_corevx_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corevx_mem_arbiter.sv
// Two-master burst-holding arbiter that shares one Avalon-style memory port between dcache (0) and icache (1).
// Define COREVX_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise port 0 has fixed priority.
module corevx_mem_arbiter #(
  parameter int unsigned BURST_W = 5,
  parameter int unsigned ADDR_W  = 34
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  p0_address,
  input  logic [BURST_W-1:0] p0_burstcount,
  input  logic               p0_read,
  input  logic               p0_write,
  input  logic [31:0]        p0_writedata,
  input  logic [3:0]         p0_byteenable,
  output logic               p0_waitrequest,
  output logic               p0_readdatavalid,
  output logic [31:0]        p0_readdata,
  output logic [1:0]         p0_response,
  input  logic [ADDR_W-1:0]  p1_address,
  input  logic [BURST_W-1:0] p1_burstcount,
  input  logic               p1_read,
  input  logic               p1_write,
  input  logic [31:0]        p1_writedata,
  input  logic [3:0]         p1_byteenable,
  output logic               p1_waitrequest,
  output logic               p1_readdatavalid,
  output logic [31:0]        p1_readdata,
  output logic [1:0]         p1_response,
  output logic [ADDR_W-1:0]  m_address,
  output logic [BURST_W-1:0] m_burstcount,
  output logic               m_read,
  output logic               m_write,
  output logic [31:0]        m_writedata,
  output logic [3:0]         m_byteenable,
  input  logic               m_waitrequest,
  input  logic               m_readdatavalid,
  input  logic [31:0]        m_readdata,
  input  logic [1:0]         m_response
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StRdata = 2'd2;

  localparam logic [BURST_W-1:0] OneBeat = BURST_W'(1);

  logic [1:0]         state_q, state_d;
  logic               grant_q, grant_d;
  logic [BURST_W-1:0] beats_q, beats_d;
  logic               prio;
  logic               done;

  logic               req0, req1;
  logic               sel_read, sel_write;
  logic [BURST_W-1:0] sel_beats;
  logic               rd_acc, wr_acc;

  assign req0 = p0_read | p0_write;
  assign req1 = p1_read | p1_write;

  // Command path follows the grant register in every state, IDLE included.
  assign m_address    = grant_q ? p1_address    : p0_address;
  assign m_burstcount = grant_q ? p1_burstcount : p0_burstcount;
  assign m_writedata  = grant_q ? p1_writedata  : p0_writedata;
  assign m_byteenable = grant_q ? p1_byteenable : p0_byteenable;

  // Read wins when a master illegally raises both strobes.
  assign sel_read  = grant_q ? p1_read : p0_read;
  assign sel_write = (grant_q ? p1_write : p0_write) & ~sel_read;
  assign sel_beats = (m_burstcount == '0) ? OneBeat : m_burstcount;

  assign rd_acc = m_read & ~m_waitrequest;
  assign wr_acc = m_write & ~m_waitrequest;

  assign p0_readdata = m_readdata;
  assign p1_readdata = m_readdata;
  assign p0_response = m_response;
  assign p1_response = m_response;

  always_comb begin
    m_read           = 1'b0;
    m_write          = 1'b0;
    p0_waitrequest   = 1'b1;
    p1_waitrequest   = 1'b1;
    p0_readdatavalid = 1'b0;
    p1_readdatavalid = 1'b0;
    case (state_q)
      StGrant: begin
        m_read  = sel_read;
        m_write = sel_write;
        if (grant_q) p1_waitrequest = m_waitrequest;
        else         p0_waitrequest = m_waitrequest;
      end
      StRdata: begin
        if (grant_q) p1_readdatavalid = m_readdatavalid;
        else         p0_readdatavalid = m_readdatavalid;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    beats_d = beats_q;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          grant_d = (req0 & req1) ? prio : req1;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (rd_acc) begin
          beats_d = sel_beats;
          state_d = StRdata;
        end else if (wr_acc) begin
          // beats is zero between transactions, so zero here marks the first write beat.
          beats_d = (beats_q == '0) ? sel_beats - OneBeat : beats_q - OneBeat;
          if (beats_d == '0) begin
            state_d = StIdle;
            done    = 1'b1;
          end
        end
      end
      StRdata: begin
        if (m_readdatavalid) begin
          beats_d = beats_q - OneBeat;
          if (beats_q == OneBeat) begin
            state_d = StIdle;
            done    = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      beats_q <= beats_d;
    end
  end

`ifdef COREVX_ARB_ROUND_ROBIN_EN
  logic prio_q, prio_d;

  // Priority passes to the loser of each completed transaction.
  assign prio_d = done ? ~grant_q : prio_q;
  assign prio   = prio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end
`else
  logic unused_done;

  assign prio        = 1'b0;
  assign unused_done = done;
`endif

endmodule

// File: tb/tb_corevx_mem_arbiter.sv
// Self-checking bench for corevx_mem_arbiter: directed literal checks, then randomized traffic
// compared every cycle against a transaction-level model (honours COREVX_ARB_ROUND_ROBIN_EN).
module tb_corevx_mem_arbiter;
  localparam int BW = 5;
  localparam int AW = 34;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] p_addr  [2];
  logic [BW-1:0] p_bc    [2];
  logic [31:0]   p_wdata [2];
  logic [3:0]    p_be    [2];
  logic [1:0]    p_rd, p_wr;
  logic          m_wait, m_rdv;
  logic [31:0]   m_rdata;
  logic [1:0]    m_resp;

  logic          p0_wait, p1_wait, p0_rdv, p1_rdv;
  logic [31:0]   p0_rdata, p1_rdata;
  logic [1:0]    p0_resp, p1_resp;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_bc;
  logic          m_rd, m_wr;
  logic [31:0]   m_wdata;
  logic [3:0]    m_be;

  corevx_mem_arbiter #(.BURST_W(BW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_address(p_addr[0]), .p0_burstcount(p_bc[0]), .p0_read(p_rd[0]), .p0_write(p_wr[0]),
    .p0_writedata(p_wdata[0]), .p0_byteenable(p_be[0]), .p0_waitrequest(p0_wait),
    .p0_readdatavalid(p0_rdv), .p0_readdata(p0_rdata), .p0_response(p0_resp),
    .p1_address(p_addr[1]), .p1_burstcount(p_bc[1]), .p1_read(p_rd[1]), .p1_write(p_wr[1]),
    .p1_writedata(p_wdata[1]), .p1_byteenable(p_be[1]), .p1_waitrequest(p1_wait),
    .p1_readdatavalid(p1_rdv), .p1_readdata(p1_rdata), .p1_response(p1_resp),
    .m_address(m_addr), .m_burstcount(m_bc), .m_read(m_rd), .m_write(m_wr),
    .m_writedata(m_wdata), .m_byteenable(m_be), .m_waitrequest(m_wait),
    .m_readdatavalid(m_rdv), .m_readdata(m_rdata), .m_response(m_resp)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff(input logic [BW-1:0] bc);
    return (bc == '0) ? 1 : int'(bc);
  endfunction

  function automatic logic [31:0] rd_pat(input logic [AW-1:0] a, input int beat);
    return a[31:0] ^ (32'h9E37_0000 + 32'(beat));
  endfunction

  function automatic logic [31:0] wr_pat(input int port, input logic [AW-1:0] a, input int beat);
    return {a[15:0], 8'(port), 8'(beat)};
  endfunction

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      p_addr[n] = '0; p_bc[n] = '0; p_wdata[n] = '0; p_be[n] = '0;
    end
    p_rd = '0; p_wr = '0;
    m_wait = 1'b0; m_rdv = 1'b0; m_rdata = '0; m_resp = '0;
  endtask

  // Called #1 after a rising edge with the arbiter idle; returns with the read accepted.
  task automatic start_read(input int n, input logic [AW-1:0] a, input logic [BW-1:0] bc);
    p_addr[n] = a; p_bc[n] = bc; p_rd[n] = 1'b1; m_wait = 1'b0;
    repeat (2) @(posedge clk);
    #1 p_rd[n] = 1'b0;
  endtask

  // ---------------- transaction-level model and random agents ----------------
  int owner, rd_left, wr_left, last_sel, prio_m, n_done;
  bit act [2];
  bit is_rd [2];
  bit rd_sent [2];
  bit junk_wr [2];
  int nbeats [2];
  int wbeat [2];
  int rbeat [2];
  int gap [2];
  logic [AW-1:0] mem_addr;
  int mem_left, mem_beat;

  task automatic model_reset();
    owner = -1; rd_left = 0; wr_left = -1; last_sel = 0; prio_m = 0; n_done = 0;
    mem_left = 0; mem_beat = 0; mem_addr = '0;
    for (int n = 0; n < 2; n++) begin
      act[n] = 0; gap[n] = 0; rd_sent[n] = 0; wbeat[n] = 0; rbeat[n] = 0;
    end
  endtask

  task automatic finish_txn(input int o);
    act[o] = 0;
    gap[o] = $urandom_range(3);
`ifdef COREVX_ARB_ROUND_ROBIN_EN
    prio_m = 1 - o;
`endif
    owner = -1; wr_left = -1; n_done++;
  endtask

  task automatic drive_masters();
    for (int n = 0; n < 2; n++) begin
      if (!act[n]) begin
        p_addr[n] = {2'(n), 32'($urandom)};
        p_bc[n] = BW'($urandom);
        p_be[n] = 4'($urandom);
        if (gap[n] > 0) gap[n]--;
        else if ($urandom_range(3) == 0) begin
          act[n] = 1; is_rd[n] = 1'($urandom_range(1));
          p_bc[n] = ($urandom_range(9) == 0) ? BW'(31) : BW'($urandom_range(6));
          nbeats[n] = eff(p_bc[n]);
          rd_sent[n] = 0; wbeat[n] = 0; rbeat[n] = 0;
          junk_wr[n] = ($urandom_range(7) == 0);
        end
      end
      p_rd[n] = act[n] & is_rd[n] & !rd_sent[n];
      p_wr[n] = act[n] & ((!is_rd[n] & (wbeat[n] < nbeats[n])) | (p_rd[n] & junk_wr[n]));
      p_wdata[n] = (act[n] && !is_rd[n]) ? wr_pat(n, p_addr[n], wbeat[n]) : $urandom;
    end
  endtask

  task automatic drive_mem();
    m_wait = ($urandom_range(9) < 3);
    if (mem_left > 0 && $urandom_range(3) != 0) begin
      m_rdv = 1'b1; m_rdata = rd_pat(mem_addr, mem_beat);
      m_resp = ($urandom_range(5) == 0) ? 2'b11 : 2'b00;
    end else begin
      // Occasional stray beat while no burst is outstanding.
      m_rdv = (mem_left == 0) && ($urandom_range(15) == 0);
      m_rdata = $urandom; m_resp = 2'($urandom);
    end
  endtask

  task automatic check_and_step();
    logic e_mrd, e_mwr;
    logic [1:0] e_wait, e_rdv;
    int s;
    bit r0, r1;
    s = (owner >= 0) ? owner : last_sel;
    e_mrd = 1'b0; e_mwr = 1'b0; e_wait = 2'b11; e_rdv = 2'b00;
    if (owner >= 0 && rd_left == 0) begin
      e_mrd = p_rd[owner];
      e_mwr = p_wr[owner] & ~p_rd[owner];
      e_wait[owner] = m_wait;
    end else if (owner >= 0) begin
      e_rdv[owner] = m_rdv;
    end
    chk("m_read", m_rd, e_mrd);
    chk("m_write", m_wr, e_mwr);
    chk("m_address", m_addr, p_addr[s]);
    chk("m_burstcount", m_bc, p_bc[s]);
    chk("m_writedata", m_wdata, p_wdata[s]);
    chk("m_byteenable", m_be, p_be[s]);
    chk("waitrequest{p1,p0}", {p1_wait, p0_wait}, e_wait);
    chk("readdatavalid{p1,p0}", {p1_rdv, p0_rdv}, e_rdv);
    chk("readdata", {p1_rdata, p0_rdata}, {m_rdata, m_rdata});
    chk("response", {p1_resp, p0_resp}, {m_resp, m_resp});
    for (int n = 0; n < 2; n++)
      if (e_rdv[n]) chk("read beat data", n == 0 ? p0_rdata : p1_rdata, rd_pat(p_addr[n], rbeat[n]));

    if (owner < 0) begin
      r0 = p_rd[0] | p_wr[0];
      r1 = p_rd[1] | p_wr[1];
      if (r0 || r1) begin
        owner = (r0 && r1) ? prio_m : (r0 ? 0 : 1);
        last_sel = owner;
      end
    end else if (rd_left == 0) begin
      if (e_mrd && !m_wait) begin
        rd_left = eff(p_bc[owner]); rd_sent[owner] = 1;
        mem_left = rd_left; mem_beat = 0; mem_addr = p_addr[owner];
      end else if (e_mwr && !m_wait) begin
        if (wr_left < 0) wr_left = eff(p_bc[owner]);
        wr_left--; wbeat[owner]++;
        if (wr_left == 0) finish_txn(owner);
      end
    end else if (m_rdv) begin
      rd_left--; mem_left--; mem_beat++; rbeat[owner]++;
      if (rd_left == 0) finish_txn(owner);
    end
  endtask

  // ---------------- test sequence ----------------
  int cnt0, cnt1, beat, stall;
  logic [AW-1:0] exp2;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk("reset p0_waitrequest", p0_wait, 1);
    chk("reset p1_waitrequest", p1_wait, 1);
    chk("reset m_read", m_rd, 0);
    chk("reset m_write", m_wr, 0);
    chk("reset readdatavalid", {p1_rdv, p0_rdv}, 2'b00);
    @(negedge clk) rst_n = 1'b1;

    // Single p0 read of 4 beats, one-cycle arbitration, stray beat after completion.
    @(posedge clk); #1;
    p_addr[0] = 34'h1_2345_6780; p_bc[0] = 4; p_rd[0] = 1'b1;
    @(negedge clk);
    chk("arb cycle m_read", m_rd, 0);
    chk("arb cycle p0_waitrequest", p0_wait, 1);
    @(posedge clk); #1;
    chk("grant m_read", m_rd, 1);
    chk("grant m_address", m_addr, 34'h1_2345_6780);
    chk("grant m_burstcount", m_bc, 4);
    chk("grant p0_waitrequest", p0_wait, 0);
    @(posedge clk); #1;
    p_rd[0] = 1'b0;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 6; i++) begin
      m_rdv = (i != 1); m_rdata = 32'hDEAD_BEAF; m_resp = 2'b00;
      @(negedge clk);
      if (p0_rdv) begin
        cnt0++;
        chk("single read data", p0_rdata, 32'hDEAD_BEAF);
      end
      if (p1_rdv) cnt1++;
      @(posedge clk); #1;
    end
    m_rdv = 1'b0;
    chk("single read p0 beats", cnt0, 4);
    chk("single read p1 beats", cnt1, 0);

    // Two-beat read with an error response on beat 1.
    start_read(0, 34'h0_0000_1000, 2);
    m_rdv = 1'b1; m_resp = 2'b11;
    @(negedge clk);
    chk("err beat1 valid", p0_rdv, 1);
    chk("err beat1 response", p0_resp, 2'b11);
    @(posedge clk); #1;
    m_resp = 2'b00;
    @(negedge clk);
    chk("err beat2 valid", p0_rdv, 1);
    chk("err beat2 response", p0_resp, 2'b00);
    @(posedge clk); #1;
    m_rdv = 1'b0;

    // burstcount 0 read completes after a single beat.
    start_read(1, 34'h2_0000_0040, 0);
    m_rdv = 1'b1;
    @(negedge clk);
    chk("bc0 beat valid", p1_rdv, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bc0 released", p1_rdv, 0);
    @(posedge clk); #1;
    m_rdv = 1'b0;

    // p1 three-beat write, beat 2 held off for two cycles.
    p_addr[1] = 34'h0_0000_2000; p_bc[1] = 3; p_wr[1] = 1'b1; p_be[1] = 4'hF;
    p_wdata[1] = 32'h00AD_BEAF;
    @(posedge clk); #1;
    chk("write m_address", m_addr, 34'h0_0000_2000);
    beat = 0; stall = 0;
    for (int i = 0; i < 5; i++) begin
      m_wait = (beat == 1 && stall < 2);
      @(negedge clk);
      chk("write p0_waitrequest", p0_wait, 1);
      chk("write m_write", m_wr, 1);
      chk("write m_writedata", m_wdata, 32'h00AD_BEAF + 32'(beat));
      chk("write p1_waitrequest", p1_wait, m_wait);
      @(posedge clk); #1;
      if (m_wait) stall++;
      else beat++;
      p_wdata[1] = 32'h00AD_BEAF + 32'(beat);
    end
    p_wr[1] = 1'b0; m_wait = 1'b0;
    @(negedge clk);
    chk("write done m_write", m_wr, 0);
    chk("write done p1_waitrequest", p1_wait, 1);

    // Asynchronous reset during beat 2 of a 4-beat read.
    @(posedge clk); #1;
    start_read(0, 34'h0_0000_3000, 4);
    m_rdv = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid-burst reset p0_readdatavalid", p0_rdv, 0);
    chk("mid-burst reset p0_waitrequest", p0_wait, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stray beat after reset", {p1_rdv, p0_rdv}, 2'b00);
    @(posedge clk); #1;
    m_rdv = 1'b0;
    p_addr[1] = 34'h3_0000_0080; p_bc[1] = 1; p_rd[1] = 1'b1;
    @(posedge clk); #1;
    chk("post-reset grant m_read", m_rd, 1);
    chk("post-reset grant m_address", m_addr, 34'h3_0000_0080);
    chk("post-reset grant p1_waitrequest", p1_wait, 0);
    @(posedge clk); #1;
    p_rd[1] = 1'b0; m_rdv = 1'b1;
    @(negedge clk);
    chk("post-reset beat", p1_rdv, 1);
    @(posedge clk); #1;
    m_rdv = 1'b0;

    // Both ports keep requesting from reset.
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef COREVX_ARB_ROUND_ROBIN_EN
    exp2 = 34'h1_0000_0100;
`else
    exp2 = 34'h0_0000_0100;
`endif
    p_addr[0] = 34'h0_0000_0100; p_addr[1] = 34'h1_0000_0100;
    p_bc[0] = 1; p_bc[1] = 1; p_rd = 2'b11;
    @(posedge clk); #1;
    chk("first winner m_address", m_addr, 34'h0_0000_0100);
    chk("first winner p1_waitrequest", p1_wait, 1);
    @(posedge clk); #1; m_rdv = 1'b1;
    @(posedge clk); #1; m_rdv = 1'b0;
    @(posedge clk); #1;
    chk("second winner m_address", m_addr, exp2);
    @(posedge clk); #1; m_rdv = 1'b1;
    @(posedge clk); #1; m_rdv = 1'b0;
    @(posedge clk); #1;
    chk("third winner m_address", m_addr, 34'h0_0000_0100);
    @(posedge clk); #1; p_rd = 2'b00; m_rdv = 1'b1;
    @(posedge clk); #1; m_rdv = 1'b0;

    // Randomized traffic against the model.
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      drive_masters();
      drive_mem();
      @(negedge clk);
      check_and_step();
    end
    chk("random traffic made progress", n_done >= 50, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
